// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access stage: funct3 encodings,
// FSM state type, timer width and the access legality helper.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int TIMER_W = $clog2(1024);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    // Legal funct3 for the access direction and natural alignment of the byte address.
    function automatic logic access_legal(input logic       is_load,
                                          input logic [2:0] f3,
                                          input logic [1:0] lane);
        logic ok;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~lane[0];
            F3_W:    ok = (lane == 2'b00);
            F3_BU:   ok = is_load;
            F3_HU:   ok = is_load & ~lane[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load formatter: selects the addressed byte/halfword of a read
// word and sign- or zero-extends it according to funct3.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
        result   = rdata;
        case (funct3)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_BU:   result = {24'h000000, byte_sel};
            F3_HU:   result = {16'h0000, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Data-memory access stage: validates the access, drives a single request to
// memory, waits for ready or timeout, and formats the load result.
module mem_access
    import mem_pkg::*;
#(
    parameter int DMEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] EX_result,
    input  logic [31:0] reg_read_data_2,
    input  logic        ID_memread,
    input  logic        ID_memwrite,
    input  logic [2:0]  ID_memfunct,
    output logic        MEM_stall,
    output logic [31:0] MEM_read_data,
    output logic        MEM_error,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata
);

    localparam logic [TIMER_W-1:0] TIMEOUT_V = TIMER_W'(DMEM_TIMEOUT);

    mem_state_t         state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         be_q, be_d;
    logic [1:0]         lane_q, lane_d;
    logic [2:0]         f3_q, f3_d;
    logic               load_q, load_d;
    logic [31:0]        rd_q, rd_d;
    logic               err_q, err_d;

    logic               access_req;
    logic               legal;
    logic [3:0]         st_be;
    logic [31:0]        st_wdata;
    logic [31:0]        load_result;

    assign access_req = ID_memread | ID_memwrite;
    assign legal      = (ID_memread ^ ID_memwrite) &&
                        access_legal(ID_memread, ID_memfunct, EX_result[1:0]);

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = reg_read_data_2;
        case (ID_memfunct)
            F3_B: begin
                st_be    = 4'b0001 << EX_result[1:0];
                st_wdata = {4{reg_read_data_2[7:0]}};
            end
            F3_H: begin
                st_be    = EX_result[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{reg_read_data_2[15:0]}};
            end
            default: ;
        endcase
    end

    mem_load_align u_load_align (
        .rdata  (dmem_rdata),
        .lane   (lane_q),
        .funct3 (f3_q),
        .result (load_result)
    );

    // Memory handshake: dmem_req stays high with constant attributes for the
    // whole BUSY phase; a cycle with dmem_req=1 and dmem_ready=1 completes the
    // transfer, and dmem_ready is meaningless while dmem_req=0.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        lane_d    = lane_q;
        f3_d      = f3_q;
        load_d    = load_q;
        rd_d      = rd_q;
        err_d     = err_q;
        MEM_stall = 1'b0;

        case (state_q)
            IDLE: begin
                if (access_req) begin
                    MEM_stall = 1'b1;
                    if (legal) begin
                        state_d = BUSY;
                        timer_d = '0;
                        req_d   = 1'b1;
                        we_d    = ID_memwrite;
                        addr_d  = {EX_result[31:2], 2'b00};
                        wdata_d = ID_memwrite ? st_wdata : 32'h0;
                        be_d    = ID_memwrite ? st_be : 4'b1111;
                        lane_d  = EX_result[1:0];
                        f3_d    = ID_memfunct;
                        load_d  = ID_memread;
                    end else begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        rd_d    = 32'h0;
                    end
                end
            end
            BUSY: begin
                MEM_stall = 1'b1;
                if (dmem_ready) begin
                    state_d = DONE;
                    err_d   = 1'b0;
                    rd_d    = load_q ? load_result : 32'h0;
                end else begin
                    timer_d = timer_q + 1'b1;
                    if (timer_d == TIMEOUT_V) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        rd_d    = 32'h0;
                    end
                end
                // Memory-side outputs return to zero as soon as BUSY ends.
                if (state_d == DONE) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = 32'h0;
                    wdata_d = 32'h0;
                    be_d    = 4'b0000;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'b0000;
            lane_q  <= 2'b00;
            f3_q    <= 3'b000;
            load_q  <= 1'b0;
            rd_q    <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            lane_q  <= lane_d;
            f3_q    <= f3_d;
            load_q  <= load_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    assign dmem_req      = req_q;
    assign dmem_we       = we_q;
    assign dmem_addr     = addr_q;
    assign dmem_wdata    = wdata_q;
    assign dmem_be       = be_q;
    assign MEM_read_data = rd_q;
    assign MEM_error     = err_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: memory responder with programmable wait
// states, scoreboard of expected {error, read_data} per access.
module tb_mem_access;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ex_result;
    logic [31:0] rs2;
    logic        memread;
    logic        memwrite;
    logic [2:0]  funct3;
    logic        mem_stall;
    logic [31:0] mem_read_data;
    logic        mem_error;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    logic [32:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    mem_access #(.DMEM_TIMEOUT(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .EX_result       (ex_result),
        .reg_read_data_2 (rs2),
        .ID_memread      (memread),
        .ID_memwrite     (memwrite),
        .ID_memfunct     (funct3),
        .MEM_stall       (mem_stall),
        .MEM_read_data   (mem_read_data),
        .MEM_error       (mem_error),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .dmem_be         (dmem_be),
        .dmem_ready      (dmem_ready),
        .dmem_rdata      (dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lane,
                                               input logic [31:0] w);
        logic [31:0] s;
        s = w >> (lane * 8);
        case (f3)
            F3_B:    return {{24{s[7]}}, s[7:0]};
            F3_H:    return {{16{s[15]}}, s[15:0]};
            F3_BU:   return {24'h0, s[7:0]};
            F3_HU:   return {16'h0, s[15:0]};
            default: return w;
        endcase
    endfunction

    task automatic idle_cycle();
        @(negedge clk);
        memread    = 1'b0;
        memwrite   = 1'b0;
        dmem_ready = 1'b0;
    endtask

    // One instruction: present it, answer requests after `waits` not-ready
    // BUSY cycles, then compare DONE outputs against the scoreboard.
    task automatic run_access(input string tag, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rdata, input int waits,
                              input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                              input int exp_occ, input int exp_reqs,
                              input logic exp_err, input logic [31:0] exp_rd,
                              input logic chk_rd);
        logic [32:0] exp;
        int  stall_cnt;
        int  req_cnt;
        bit  done;
        @(negedge clk);
        ex_result  = addr;
        rs2        = wd;
        memread    = rd;
        memwrite   = wr;
        funct3     = f3;
        dmem_ready = 1'b0;
        exp_q.push_back({exp_err, exp_rd});
        stall_cnt = 0;
        req_cnt   = 0;
        done      = 0;
        for (int cyc = 0; cyc < 1100 && !done; cyc++) begin
            #1;
            if (dmem_req) begin
                req_cnt++;
                if (req_cnt == 1) begin
                    check({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
                    check({tag, "_be"}, dmem_be, exp_be);
                    check({tag, "_we"}, dmem_we, wr);
                    if (wr) check({tag, "_wdata"}, dmem_wdata, exp_wdata);
                end
                dmem_ready = (req_cnt > waits);
                dmem_rdata = dmem_ready ? rdata : 32'hDEAD_BEEF;
            end else begin
                dmem_ready = 1'b0;
            end
            if (mem_stall) begin
                stall_cnt++;
            end else if (stall_cnt > 0) begin
                done = 1;
                exp  = exp_q.pop_front();
                check({tag, "_err"}, mem_error, exp[32]);
                if (chk_rd) check({tag, "_rdata"}, mem_read_data, exp[31:0]);
                check({tag, "_done_req"}, dmem_req, 1'b0);
                check({tag, "_stall_cycles"}, stall_cnt, exp_occ - 1);
                check({tag, "_reqs"}, req_cnt, exp_reqs);
            end
            if (!done) @(negedge clk);
        end
        if (!done) begin
            void'(exp_q.pop_front());
            check({tag, "_completion_bound"}, 1'b0, 1'b1);
        end
        dmem_ready = 1'b0;
    endtask

    initial begin
        logic [2:0] f3s[5];
        logic [2:0] f3;
        logic [1:0] lane;
        logic [31:0] a;
        logic [31:0] w;
        int wt;
        f3s = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};

        rst = 1'b1; ex_result = 32'h0; rs2 = 32'h0; memread = 1'b0; memwrite = 1'b0;
        funct3 = 3'b000; dmem_ready = 1'b0; dmem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_req", dmem_req, 1'b0);
        check("rst_we", dmem_we, 1'b0);
        check("rst_addr", dmem_addr, 32'h0);
        check("rst_wdata", dmem_wdata, 32'h0);
        check("rst_be", dmem_be, 4'h0);
        check("rst_rdata", mem_read_data, 32'h0);
        check("rst_err", mem_error, 1'b0);
        check("rst_stall", mem_stall, 1'b0);

        run_access("lb_neg", 1, 0, F3_B, 32'h0000_0103, 32'h0, 32'h80AA_BBCC, 0,
                   4'b1111, 32'h0, 3, 1, 0, 32'hFFFF_FF80, 1);
        idle_cycle();
        run_access("sh_hi", 0, 1, F3_H, 32'h0000_0202, 32'h1234_5678, 32'h0, 0,
                   4'b1100, 32'h5678_5678, 3, 1, 0, 32'h0, 0);
        run_access("sb_1", 0, 1, F3_B, 32'h0000_0201, 32'h0000_00AB, 32'h0, 0,
                   4'b0010, 32'hABAB_ABAB, 3, 1, 0, 32'h0, 0);
        idle_cycle();
        run_access("lw_mis", 1, 0, F3_W, 32'h0000_0101, 32'h0, 32'h0, 0,
                   4'b1111, 32'h0, 2, 0, 1, 32'h0, 0);
        run_access("ld_f3_011", 1, 0, 3'b011, 32'h0000_0100, 32'h0, 32'h0, 0,
                   4'b1111, 32'h0, 2, 0, 1, 32'h0, 0);
        run_access("rd_and_wr", 1, 1, F3_W, 32'h0000_0100, 32'h0, 32'h0, 0,
                   4'b1111, 32'h0, 2, 0, 1, 32'h0, 0);
        run_access("st_f3_100", 0, 1, F3_BU, 32'h0000_0100, 32'h0, 32'h0, 0,
                   4'b1111, 32'h0, 2, 0, 1, 32'h0, 0);
        run_access("sh_mis", 0, 1, F3_H, 32'h0000_0203, 32'h0, 32'h0, 0,
                   4'b0011, 32'h0, 2, 0, 1, 32'h0, 0);
        run_access("lhu_mis", 1, 0, F3_HU, 32'h0000_0001, 32'h0, 32'h0, 0,
                   4'b1111, 32'h0, 2, 0, 1, 32'h0, 0);
        run_access("sw_ok", 0, 1, F3_W, 32'h0000_0204, 32'h0BAD_CAFE, 32'h0, 0,
                   4'b1111, 32'h0BAD_CAFE, 3, 1, 0, 32'h0, 0);
        idle_cycle();
        run_access("timeout", 1, 0, F3_W, 32'h0000_0300, 32'h0, 32'h1111_2222, 5000,
                   4'b1111, 32'h0, 6, 4, 1, 32'h0, 1);
        idle_cycle();

        // Reset pulsed during the second BUSY cycle of a load.
        @(negedge clk);
        ex_result = 32'h0000_0500; memread = 1'b1; memwrite = 1'b0; funct3 = F3_W;
        #1 check("rstmid_idle_stall", mem_stall, 1'b1);
        @(negedge clk);
        #1 check("rstmid_busy1_req", dmem_req, 1'b1);
        @(negedge clk);
        #1 check("rstmid_busy2_req", dmem_req, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; memread = 1'b0;
        #1;
        check("rstmid_req", dmem_req, 1'b0);
        check("rstmid_be", dmem_be, 4'h0);
        check("rstmid_addr", dmem_addr, 32'h0);
        check("rstmid_err", mem_error, 1'b0);
        check("rstmid_rdata", mem_read_data, 32'h0);
        check("rstmid_stall", mem_stall, 1'b0);

        run_access("lhu_after_rst", 1, 0, F3_HU, 32'h0000_0002, 32'h0, 32'hF00D_0000, 0,
                   4'b1111, 32'h0, 3, 1, 0, 32'h0000_F00D, 1);
        idle_cycle();

        run_access("b2b_lw", 1, 0, F3_W, 32'h0000_0400, 32'h0, 32'h1122_3344, 1,
                   4'b1111, 32'h0, 4, 2, 0, 32'h1122_3344, 1);
        run_access("b2b_sw", 0, 1, F3_W, 32'h0000_0404, 32'hCAFE_F00D, 32'h0, 1,
                   4'b1111, 32'hCAFE_F00D, 4, 2, 0, 32'h0, 0);
        idle_cycle();

        for (int i = 0; i < 8; i++) begin
            f3   = f3s[$urandom_range(0, 4)];
            lane = 2'($urandom_range(0, 3));
            if (f3 == F3_W) lane = 2'b00;
            else if (f3 == F3_H || f3 == F3_HU) lane[0] = 1'b0;
            a  = ($urandom() & 32'hFFFF_FFFC) | {30'h0, lane};
            w  = $urandom();
            wt = $urandom_range(0, 3);
            run_access("rnd_load", 1, 0, f3, a, 32'h0, w, wt,
                       4'b1111, 32'h0, 3 + wt, 1 + wt, 0, model_load(f3, lane, w), 1);
        end
        idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
